axis_decouple_pipe: RTL and testbench
=====================================

Name: axis_decouple_pipe

Overview:
- Parametrised successor to the single-slice AXI-Stream decouple block.
- Chains STAGES register slices between a slave and a master AXI-Stream port to break timing on tdata/tvalid/tready paths.
- Selectable slice type: bypass, simple, or full-throughput skid. tuser width is generalised; tlast can be compiled out.
- Sits between any two AXI-Stream agents in the datapath, e.g. MAC to FIFO, or between long-route floorplan regions.

Parameters:
- DATA_WIDTH, 32, tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is driven all-ones.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- LAST_ENABLE, 1, propagate tlast; when 0, m_axis_tlast is driven 1.
- USER_WIDTH, 1, tuser width (legal range 1..64).
- STAGES, 2, number of chained slices (legal range 1..16).
- REG_TYPE, 2, slice type: 0 = bypass (wires), 1 = simple, 2 = skid.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  USER_WIDTH  input sideband.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  USER_WIDTH  output sideband.

Behaviour:
- Reset (asynchronous assert, released on a clk edge):
  - all slice valid and skid-valid flags clear;
  - m_axis_tvalid=0; s_axis_tready=0 while rst=1, then 1 on the first clk edge after release;
  - m_axis_tdata/tkeep/tlast/tuser reset to 0.
- Reset mid-operation: all held beats are discarded; no partial frame is emitted after release.
- Handshake: a transfer occurs on a clk edge where tvalid&tready=1.
  - Once m_axis_tvalid is asserted, it and its payload stay stable until m_axis_tready=1.
  - Beat order is preserved; no beat is dropped or duplicated.
- Payload: tdata, tkeep, tlast and tuser travel together as one word.
  - Disabled fields cost no flops.
- REG_TYPE=0: pure wires, latency 0, STAGES ignored.
- REG_TYPE=1 (simple slice):
  - one register per stage; stage ready = !valid, registered;
  - steady-state throughput is 1 beat per 2 cycles per stage;
  - latency STAGES cycles; capacity STAGES beats.
- REG_TYPE=2 (skid slice): each stage has a main register and a skid register.
  - Stage input ready is registered: ready_next = !skid_valid_next.
  - Empty state: an input beat loads main.
  - Main full and downstream ready: main is replaced by the input (or emptied).
  - Main full, downstream not ready, input arrives while ready=1: beat goes to skid and ready drops next cycle.
  - When downstream accepts main: skid moves to main and ready rises next cycle.
  - Full throughput (1 beat/cycle) under continuous ready.
  - Latency is STAGES cycles from s-handshake to m_axis_tvalid; capacity 2*STAGES beats.
- Stage interconnect: each stage's tready is driven only by the next stage's registered ready. There is no combinational path from m_axis_tready to s_axis_tready when REG_TYPE is not 0.
- Simultaneous events:
  - input accept and output accept in the same cycle on a stage with main full and skid empty: main takes the new beat, skid stays empty;
  - skid full: s-side ready is already 0, so no accept occurs.

Optional Feature:
- Macro: AXIS_DECOUPLE_OCC_EN.
- When defined:
  - adds output port occupancy, width $clog2(2*STAGES+1), holding the number of beats currently held;
  - +1 on an s-handshake, -1 on an m-handshake, unchanged when both occur in the same cycle;
  - resets to 0; reads 0 when REG_TYPE=0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- REG_TYPE=2, STAGES=2, m_axis_tready=1, 8 back-to-back beats with tdata=0x00000001..0x00000008 -> first m_axis_tvalid 2 cycles after the first handshake; 8 consecutive output beats in order, tlast only on beat 8.
- REG_TYPE=2, STAGES=2, m_axis_tready=0 for 10 cycles while streaming -> exactly 4 beats accepted, s_axis_tready=0 from cycle 5; m_axis_tready=1 then drains 0x1..0x4 in order with no gaps.
- REG_TYPE=1, STAGES=1, continuous valid and ready -> s_axis_tready toggles; 4 beats delivered in 8 cycles.
- Random valid/ready (50% each), REG_TYPE=2, STAGES=3, 1000 beats with tkeep=0x7 on tlast beats and USER_WIDTH=4 -> scoreboard exact match; m_axis_tvalid never drops without a handshake.
- rst pulsed for 1 cycle with 3 beats held -> m_axis_tvalid=0 immediately; the next output is the first post-reset input beat; occupancy=0 when AXIS_DECOUPLE_OCC_EN is defined.
- REG_TYPE=0 -> m_axis_tready passes through to s_axis_tready in the same cycle; zero latency.

Source files
------------

// File: rtl/axis_decouple_pipe.sv
// AXI-Stream decouple pipeline: STAGES chained slices, each bypass, simple or skid (REG_TYPE).
// Define AXIS_DECOUPLE_OCC_EN to add the occupancy output (beats currently held).

module axis_decouple_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LAST_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int STAGES      = 2,
    parameter int REG_TYPE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef AXIS_DECOUPLE_OCC_EN
    ,
    output logic [$clog2(2*STAGES+1)-1:0] occupancy
`endif
);

    // Disabled sideband fields are left out of the stored word entirely.
    localparam int KW       = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 0;
    localparam int LW       = (LAST_ENABLE != 0) ? 1 : 0;
    localparam int PW       = DATA_WIDTH + KW + LW + USER_WIDTH;
    localparam int LAST_OFS = DATA_WIDTH + KW;
    localparam int USER_OFS = LAST_OFS + LW;

    genvar gi;

    logic [PW-1:0] s_word;
    logic [PW-1:0] m_word;

    assign s_word[DATA_WIDTH-1:0]         = s_axis_tdata;
    assign s_word[USER_OFS +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tdata = m_word[DATA_WIDTH-1:0];
    assign m_axis_tuser = m_word[USER_OFS +: USER_WIDTH];

    if (KEEP_ENABLE != 0) begin : g_keep
        assign s_word[DATA_WIDTH +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep = m_word[DATA_WIDTH +: KEEP_WIDTH];
    end else begin : g_no_keep
        logic keep_unused;
        assign keep_unused  = ^s_axis_tkeep;
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign s_word[LAST_OFS] = s_axis_tlast;
        assign m_axis_tlast     = m_word[LAST_OFS];
    end else begin : g_no_last
        logic last_unused;
        assign last_unused  = s_axis_tlast;
        assign m_axis_tlast = 1'b1;
    end

    if (REG_TYPE == 0) begin : g_bypass
        logic clk_rst_unused;
        assign clk_rst_unused = clk ^ rst;
        assign m_word         = s_word;
        assign m_axis_tvalid  = s_axis_tvalid;
        assign s_axis_tready  = m_axis_tready;
    end else begin : g_pipe
        // Index gi is the input of stage gi; index STAGES is the master port.
        logic [PW-1:0] pipe_data  [0:STAGES];
        logic          pipe_valid [0:STAGES];
        logic          pipe_ready [0:STAGES];

        assign pipe_data[0]       = s_word;
        assign pipe_valid[0]      = s_axis_tvalid;
        assign pipe_ready[STAGES] = m_axis_tready;
        assign s_axis_tready      = pipe_ready[0];
        assign m_word             = pipe_data[STAGES];
        assign m_axis_tvalid      = pipe_valid[STAGES];

        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [PW-1:0] in_data;
            logic          in_valid;
            logic          out_ready;
            logic          in_xfer;
            logic [PW-1:0] main_data_reg, main_data_next;
            logic          main_valid_reg, main_valid_next;
            logic          ready_reg, ready_next;

            assign in_data   = pipe_data[gi];
            assign in_valid  = pipe_valid[gi];
            assign out_ready = pipe_ready[gi+1];
            assign in_xfer   = in_valid & ready_reg;

            if (REG_TYPE == 1) begin : g_simple
                // Ready is simply "empty", so a stage never loads and unloads in one cycle.
                always_comb begin
                    main_valid_next = main_valid_reg;
                    main_data_next  = main_data_reg;
                    if (in_xfer) begin
                        main_valid_next = 1'b1;
                        main_data_next  = in_data;
                    end else if (out_ready) begin
                        main_valid_next = 1'b0;
                    end
                    ready_next = !main_valid_next;
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        main_valid_reg <= 1'b0;
                        main_data_reg  <= '0;
                        ready_reg      <= 1'b0;
                    end else begin
                        main_valid_reg <= main_valid_next;
                        main_data_reg  <= main_data_next;
                        ready_reg      <= ready_next;
                    end
                end
            end else begin : g_skid
                logic [PW-1:0] skid_data_reg, skid_data_next;
                logic          skid_valid_reg, skid_valid_next;

                // The skid slot absorbs the one beat accepted while ready was still high.
                always_comb begin
                    main_valid_next = main_valid_reg;
                    main_data_next  = main_data_reg;
                    skid_valid_next = skid_valid_reg;
                    skid_data_next  = skid_data_reg;
                    if (!main_valid_reg || out_ready) begin
                        if (skid_valid_reg) begin
                            main_data_next  = skid_data_reg;
                            main_valid_next = 1'b1;
                            skid_valid_next = 1'b0;
                        end else if (in_xfer) begin
                            main_data_next  = in_data;
                            main_valid_next = 1'b1;
                        end else begin
                            main_valid_next = 1'b0;
                        end
                    end else if (in_xfer) begin
                        skid_data_next  = in_data;
                        skid_valid_next = 1'b1;
                    end
                    ready_next = !skid_valid_next;
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        main_valid_reg <= 1'b0;
                        main_data_reg  <= '0;
                        skid_valid_reg <= 1'b0;
                        skid_data_reg  <= '0;
                        ready_reg      <= 1'b0;
                    end else begin
                        main_valid_reg <= main_valid_next;
                        main_data_reg  <= main_data_next;
                        skid_valid_reg <= skid_valid_next;
                        skid_data_reg  <= skid_data_next;
                        ready_reg      <= ready_next;
                    end
                end
            end

            assign pipe_ready[gi]   = ready_reg;
            assign pipe_data[gi+1]  = main_data_reg;
            assign pipe_valid[gi+1] = main_valid_reg;
        end
    end

`ifdef AXIS_DECOUPLE_OCC_EN
    localparam int OCC_W = $clog2(2*STAGES+1);

    if (REG_TYPE == 0) begin : g_occ_none
        assign occupancy = '0;
    end else begin : g_occ
        logic [OCC_W-1:0] occ_reg;
        logic             s_hs;
        logic             m_hs;

        assign s_hs = s_axis_tvalid & s_axis_tready;
        assign m_hs = m_axis_tvalid & m_axis_tready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_reg <= '0;
            end else if (s_hs && !m_hs) begin
                occ_reg <= occ_reg + OCC_W'(1);
            end else if (!s_hs && m_hs) begin
                occ_reg <= occ_reg - OCC_W'(1);
            end
        end

        assign occupancy = occ_reg;
    end
`endif

endmodule

// File: tb/tb_axis_decouple_pipe.sv
// Self-checking bench for axis_decouple_pipe: four instances (skid x2 stages, simple x1,
// skid x3 with 4-bit tuser, bypass) sharing one clock and reset, each with a scoreboard.

module tb_axis_decouple_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- instance A: skid, 2 stages ----------------
    logic [31:0] a_sdata, a_mdata;
    logic [3:0]  a_skeep, a_mkeep;
    logic        a_svalid, a_sready, a_slast, a_mvalid, a_mready, a_mlast;
    logic [0:0]  a_suser, a_muser;
    logic [37:0] a_sword, a_mword, a_prev_word, a_exp;
    logic        a_prev_stall = 1'b0;
    logic [37:0] qa[$];
    int          a_in_cyc[$];
    int          a_out_cyc[$];
    assign a_sword = {a_slast, a_suser, a_skeep, a_sdata};
    assign a_mword = {a_mlast, a_muser, a_mkeep, a_mdata};

    // ---------------- instance B: simple, 1 stage ----------------
    logic [31:0] b_sdata, b_mdata;
    logic [3:0]  b_skeep, b_mkeep;
    logic        b_svalid, b_sready, b_slast, b_mvalid, b_mready, b_mlast;
    logic [0:0]  b_suser, b_muser;
    logic [37:0] b_sword, b_mword, b_exp;
    logic [37:0] qb[$];
    int          b_out_cnt = 0;
    assign b_sword = {b_slast, b_suser, b_skeep, b_sdata};
    assign b_mword = {b_mlast, b_muser, b_mkeep, b_mdata};

    // ---------------- instance C: skid, 3 stages, 4-bit tuser ----------------
    logic [31:0] c_sdata, c_mdata;
    logic [3:0]  c_skeep, c_mkeep;
    logic        c_svalid, c_sready, c_slast, c_mvalid, c_mready, c_mlast;
    logic [3:0]  c_suser, c_muser;
    logic [40:0] c_sword, c_mword, c_prev_word, c_exp;
    logic        c_prev_stall = 1'b0;
    logic [40:0] qc[$];
    int          c_out_cnt = 0;
    assign c_sword = {c_slast, c_suser, c_skeep, c_sdata};
    assign c_mword = {c_mlast, c_muser, c_mkeep, c_mdata};

    // ---------------- instance D: bypass ----------------
    logic [31:0] d_sdata, d_mdata;
    logic [3:0]  d_skeep, d_mkeep;
    logic        d_svalid, d_sready, d_slast, d_mvalid, d_mready, d_mlast;
    logic [0:0]  d_suser, d_muser;
    logic [37:0] d_sword, d_mword, d_exp;
    logic [37:0] qd[$];
    assign d_sword = {d_slast, d_suser, d_skeep, d_sdata};
    assign d_mword = {d_mlast, d_muser, d_mkeep, d_mdata};

`ifdef AXIS_DECOUPLE_OCC_EN
    logic [2:0] a_occ, c_occ, d_occ;
    logic [1:0] b_occ;
`endif

    axis_decouple_pipe #(.DATA_WIDTH(32), .USER_WIDTH(1), .STAGES(2), .REG_TYPE(2)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_sdata), .s_axis_tkeep(a_skeep), .s_axis_tvalid(a_svalid),
        .s_axis_tready(a_sready), .s_axis_tlast(a_slast), .s_axis_tuser(a_suser),
        .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tvalid(a_mvalid),
        .m_axis_tready(a_mready), .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser)
`ifdef AXIS_DECOUPLE_OCC_EN
        , .occupancy(a_occ)
`endif
    );

    axis_decouple_pipe #(.DATA_WIDTH(32), .USER_WIDTH(1), .STAGES(1), .REG_TYPE(1)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_sdata), .s_axis_tkeep(b_skeep), .s_axis_tvalid(b_svalid),
        .s_axis_tready(b_sready), .s_axis_tlast(b_slast), .s_axis_tuser(b_suser),
        .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(b_mready), .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser)
`ifdef AXIS_DECOUPLE_OCC_EN
        , .occupancy(b_occ)
`endif
    );

    axis_decouple_pipe #(.DATA_WIDTH(32), .USER_WIDTH(4), .STAGES(3), .REG_TYPE(2)) dut_c (
        .clk(clk), .rst(rst),
        .s_axis_tdata(c_sdata), .s_axis_tkeep(c_skeep), .s_axis_tvalid(c_svalid),
        .s_axis_tready(c_sready), .s_axis_tlast(c_slast), .s_axis_tuser(c_suser),
        .m_axis_tdata(c_mdata), .m_axis_tkeep(c_mkeep), .m_axis_tvalid(c_mvalid),
        .m_axis_tready(c_mready), .m_axis_tlast(c_mlast), .m_axis_tuser(c_muser)
`ifdef AXIS_DECOUPLE_OCC_EN
        , .occupancy(c_occ)
`endif
    );

    axis_decouple_pipe #(.DATA_WIDTH(32), .USER_WIDTH(1), .STAGES(2), .REG_TYPE(0)) dut_d (
        .clk(clk), .rst(rst),
        .s_axis_tdata(d_sdata), .s_axis_tkeep(d_skeep), .s_axis_tvalid(d_svalid),
        .s_axis_tready(d_sready), .s_axis_tlast(d_slast), .s_axis_tuser(d_suser),
        .m_axis_tdata(d_mdata), .m_axis_tkeep(d_mkeep), .m_axis_tvalid(d_mvalid),
        .m_axis_tready(d_mready), .m_axis_tlast(d_mlast), .m_axis_tuser(d_muser)
`ifdef AXIS_DECOUPLE_OCC_EN
        , .occupancy(d_occ)
`endif
    );

    // ---------------- scoreboard monitors (sample on falling edge) ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            qa.delete();
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                checks++;
                if (a_mvalid !== 1'b1 || a_mword !== a_prev_word) begin
                    errors++;
                    $display("FAIL a_hold got valid=%b word=%h expected valid=1 word=%h", a_mvalid, a_mword, a_prev_word);
                end
            end
            if (a_svalid && a_sready) begin
                qa.push_back(a_sword);
                a_in_cyc.push_back(cyc);
            end
            if (a_mvalid && a_mready) begin
                checks++;
                a_out_cyc.push_back(cyc);
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_sb got unexpected word=%h expected none", a_mword);
                end else begin
                    a_exp = qa.pop_front();
                    if (a_mword !== a_exp) begin
                        errors++;
                        $display("FAIL a_sb got %h expected %h", a_mword, a_exp);
                    end
                end
            end
            a_prev_stall = a_mvalid && !a_mready;
            a_prev_word  = a_mword;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            qb.delete();
        end else begin
            if (b_svalid && b_sready) qb.push_back(b_sword);
            if (b_mvalid && b_mready) begin
                checks++;
                b_out_cnt++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_sb got unexpected word=%h expected none", b_mword);
                end else begin
                    b_exp = qb.pop_front();
                    if (b_mword !== b_exp) begin
                        errors++;
                        $display("FAIL b_sb got %h expected %h", b_mword, b_exp);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            qc.delete();
            c_prev_stall = 1'b0;
        end else begin
            if (c_prev_stall) begin
                checks++;
                if (c_mvalid !== 1'b1 || c_mword !== c_prev_word) begin
                    errors++;
                    $display("FAIL c_hold got valid=%b word=%h expected valid=1 word=%h", c_mvalid, c_mword, c_prev_word);
                end
            end
            if (c_svalid && c_sready) qc.push_back(c_sword);
            if (c_mvalid && c_mready) begin
                checks++;
                c_out_cnt++;
                if (qc.size() == 0) begin
                    errors++;
                    $display("FAIL c_sb got unexpected word=%h expected none", c_mword);
                end else begin
                    c_exp = qc.pop_front();
                    if (c_mword !== c_exp) begin
                        errors++;
                        $display("FAIL c_sb got %h expected %h", c_mword, c_exp);
                    end
                end
            end
            c_prev_stall = c_mvalid && !c_mready;
            c_prev_word  = c_mword;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            qd.delete();
        end else begin
            if (d_svalid && d_sready) qd.push_back(d_sword);
            if (d_mvalid && d_mready) begin
                checks++;
                if (qd.size() == 0) begin
                    errors++;
                    $display("FAIL d_sb got unexpected word=%h expected none", d_mword);
                end else begin
                    d_exp = qd.pop_front();
                    if (d_mword !== d_exp) begin
                        errors++;
                        $display("FAIL d_sb got %h expected %h", d_mword, d_exp);
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (a_sready !== 1'b0) begin errors++; $display("FAIL reset_a_sready got %b expected 0", a_sready); end
        checks++;
        if (a_mvalid !== 1'b0) begin errors++; $display("FAIL reset_a_mvalid got %b expected 0", a_mvalid); end
        checks++;
        if (a_mword !== 38'h0) begin errors++; $display("FAIL reset_a_payload got %h expected 0", a_mword); end
        checks++;
        if (c_mvalid !== 1'b0 || c_sready !== 1'b0) begin errors++; $display("FAIL reset_c got valid=%b ready=%b expected 0 0", c_mvalid, c_sready); end
        checks++;
        if (b_sready !== 1'b0 || b_mvalid !== 1'b0) begin errors++; $display("FAIL reset_b got ready=%b valid=%b expected 0 0", b_sready, b_mvalid); end
`ifdef AXIS_DECOUPLE_OCC_EN
        checks++;
        if (a_occ !== 3'd0) begin errors++; $display("FAIL reset_a_occ got %0d expected 0", a_occ); end
`endif
        rst = 1'b0;
        checks++;
        if (a_sready !== 1'b0) begin errors++; $display("FAIL release_a_sready_early got %b expected 0", a_sready); end
        tick();
        checks++;
        if (a_sready !== 1'b1) begin errors++; $display("FAIL release_a_sready got %b expected 1", a_sready); end
        checks++;
        if (b_sready !== 1'b1 || c_sready !== 1'b1) begin errors++; $display("FAIL release_bc_sready got %b %b expected 1 1", b_sready, c_sready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        int  tries;
        logic hs;
        a_in_cyc.delete();
        a_out_cyc.delete();
        a_mready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_sdata  = 32'(i + 1);
            a_skeep  = 4'hF;
            a_slast  = (i == 7);
            a_suser  = 1'(i & 1);
            a_svalid = 1'b1;
            tries = 0;
            do begin
                @(negedge clk);
                hs = a_sready;
                tick();
                tries++;
            end while (!hs && tries < 20);
            if (!hs) begin errors++; checks++; $display("FAIL b2b_accept got timeout expected handshake beat %0d", i + 1); end
        end
        a_svalid = 1'b0;
        a_slast  = 1'b0;
        for (int t = 0; t < 30 && a_out_cyc.size() < 8; t++) tick();
        checks++;
        if (a_out_cyc.size() != 8 || a_in_cyc.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got out=%0d in=%0d expected 8 8", a_out_cyc.size(), a_in_cyc.size());
        end else begin
            checks++;
            if (a_in_cyc[7] != a_in_cyc[0] + 7) begin errors++; $display("FAIL b2b_in_gap got span %0d expected 7", a_in_cyc[7] - a_in_cyc[0]); end
            checks++;
            if (a_out_cyc[0] != a_in_cyc[0] + 2) begin errors++; $display("FAIL b2b_latency got %0d expected 2", a_out_cyc[0] - a_in_cyc[0]); end
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (a_out_cyc[k] != a_out_cyc[0] + k) begin errors++; $display("FAIL b2b_out_gap beat %0d got offset %0d expected %0d", k + 1, a_out_cyc[k] - a_out_cyc[0], k); end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_backpressure();
        int   acc;
        int   nxt;
        logic rdy_hist [10];
        a_in_cyc.delete();
        a_out_cyc.delete();
        a_mready = 1'b0;
        acc = 0;
        nxt = 1;
        for (int k = 0; k < 10; k++) begin
            a_sdata  = 32'(nxt);
            a_skeep  = 4'hF;
            a_slast  = 1'b0;
            a_suser  = 1'b0;
            a_svalid = 1'b1;
            @(negedge clk);
            rdy_hist[k] = a_sready;
            if (a_sready) begin acc++; nxt++; end
            tick();
        end
        a_svalid = 1'b0;
        checks++;
        if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d expected 4", acc); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rdy_hist[k] !== (k < 4)) begin errors++; $display("FAIL bp_sready cycle %0d got %b expected %b", k + 1, rdy_hist[k], (k < 4)); end
        end
`ifdef AXIS_DECOUPLE_OCC_EN
        checks++;
        if (a_occ !== 3'd4) begin errors++; $display("FAIL bp_occ got %0d expected 4", a_occ); end
`endif
        a_mready = 1'b1;
        for (int t = 0; t < 20 && a_out_cyc.size() < 4; t++) tick();
        repeat (3) tick();
        checks++;
        if (a_out_cyc.size() != 4) begin
            errors++;
            $display("FAIL bp_drain_count got %0d expected 4", a_out_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (a_out_cyc[k] != a_out_cyc[0] + k) begin errors++; $display("FAIL bp_drain_gap beat %0d got offset %0d expected %0d", k + 1, a_out_cyc[k] - a_out_cyc[0], k); end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_simple();
        int   acc;
        int   start_cnt;
        logic rdy_hist [8];
        b_mready  = 1'b1;
        acc       = 0;
        start_cnt = b_out_cnt;
        for (int k = 0; k < 8; k++) begin
            b_sdata  = 32'h5000 + 32'(acc);
            b_skeep  = 4'hF;
            b_slast  = (acc == 3);
            b_suser  = 1'b1;
            b_svalid = 1'b1;
            @(negedge clk);
            rdy_hist[k] = b_sready;
            if (b_sready) acc++;
            tick();
        end
        b_svalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rdy_hist[k] !== (k % 2 == 0)) begin errors++; $display("FAIL simple_sready cycle %0d got %b expected %b", k + 1, rdy_hist[k], (k % 2 == 0)); end
        end
        checks++;
        if (acc != 4) begin errors++; $display("FAIL simple_accepted got %0d expected 4", acc); end
        checks++;
        if (b_out_cnt - start_cnt != 4) begin errors++; $display("FAIL simple_delivered got %0d expected 4", b_out_cnt - start_cnt); end
        $display("test_simple done");
    endtask

    task automatic test_random();
        int   sent;
        int   guard;
        logic hs_prev;
        c_out_cnt = 0;
        sent      = 0;
        guard     = 0;
        hs_prev   = 1'b0;
        c_svalid  = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            if (!c_svalid || hs_prev) begin
                c_svalid = ($urandom_range(0, 1) == 1);
                if (c_svalid) begin
                    c_sdata = $urandom;
                    c_slast = ($urandom_range(0, 7) == 0);
                    c_skeep = c_slast ? 4'h7 : 4'hF;
                    c_suser = 4'($urandom_range(0, 15));
                end
            end
            c_mready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            hs_prev = c_svalid && c_sready;
            if (hs_prev) sent++;
            tick();
            guard++;
        end
        c_svalid = 1'b0;
        c_mready = 1'b1;
        for (int t = 0; t < 200 && c_out_cnt < 1000; t++) tick();
        checks++;
        if (sent != 1000) begin errors++; $display("FAIL rand_sent got %0d expected 1000", sent); end
        checks++;
        if (c_out_cnt != 1000) begin errors++; $display("FAIL rand_delivered got %0d expected 1000", c_out_cnt); end
        checks++;
        if (qc.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d expected 0", qc.size()); end
        $display("test_random done sent=%0d delivered=%0d", sent, c_out_cnt);
    endtask

    task automatic test_reset_mid();
        int   tries;
        logic hs;
        logic seen;
        a_mready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_sdata  = 32'h100 + 32'(i);
            a_skeep  = 4'hF;
            a_slast  = 1'b0;
            a_suser  = 1'b0;
            a_svalid = 1'b1;
            tries = 0;
            do begin
                @(negedge clk);
                hs = a_sready;
                tick();
                tries++;
            end while (!hs && tries < 20);
        end
        a_svalid = 1'b0;
        repeat (2) tick();
        checks++;
        if (a_mvalid !== 1'b1) begin errors++; $display("FAIL rmid_held got valid=%b expected 1", a_mvalid); end
`ifdef AXIS_DECOUPLE_OCC_EN
        checks++;
        if (a_occ !== 3'd3) begin errors++; $display("FAIL rmid_occ_before got %0d expected 3", a_occ); end
`endif
        rst = 1'b1;
        #1;
        checks++;
        if (a_mvalid !== 1'b0) begin errors++; $display("FAIL rmid_mvalid got %b expected 0", a_mvalid); end
        checks++;
        if (a_sready !== 1'b0 || a_mword !== 38'h0) begin errors++; $display("FAIL rmid_state got ready=%b word=%h expected 0 0", a_sready, a_mword); end
        tick();
        rst = 1'b0;
`ifdef AXIS_DECOUPLE_OCC_EN
        checks++;
        if (a_occ !== 3'd0) begin errors++; $display("FAIL rmid_occ_after got %0d expected 0", a_occ); end
`endif
        a_mready = 1'b1;
        a_sdata  = 32'hA5A5_0001;
        a_skeep  = 4'hF;
        a_slast  = 1'b1;
        a_suser  = 1'b1;
        a_svalid = 1'b1;
        tries = 0;
        do begin
            @(negedge clk);
            hs = a_sready;
            tick();
            tries++;
        end while (!hs && tries < 20);
        a_svalid = 1'b0;
        a_slast  = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (a_mvalid) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || a_mdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL rmid_first_out got valid=%b data=%h expected 1 a5a50001", seen, a_mdata);
        end
        tick();
        repeat (3) tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_bypass();
        logic [37:0] want;
        d_svalid = 1'b0;
        d_mready = 1'b0;
        #1;
        checks++;
        if (d_sready !== 1'b0) begin errors++; $display("FAIL byp_ready_lo got %b expected 0", d_sready); end
        d_mready = 1'b1;
        #1;
        checks++;
        if (d_sready !== 1'b1) begin errors++; $display("FAIL byp_ready_hi got %b expected 1", d_sready); end
        d_sdata  = 32'hDEAD_BEEF;
        d_skeep  = 4'h5;
        d_slast  = 1'b1;
        d_suser  = 1'b1;
        d_svalid = 1'b1;
        want = {1'b1, 1'b1, 4'h5, 32'hDEAD_BEEF};
        #1;
        checks++;
        if (d_mvalid !== 1'b1 || d_mword !== want) begin errors++; $display("FAIL byp_comb got valid=%b word=%h expected 1 %h", d_mvalid, d_mword, want); end
        tick();
        for (int k = 0; k < 5; k++) begin
            d_sdata = $urandom;
            d_skeep = 4'($urandom_range(0, 15));
            d_slast = (k == 4);
            d_suser = 1'($urandom_range(0, 1));
            tick();
        end
        d_svalid = 1'b0;
`ifdef AXIS_DECOUPLE_OCC_EN
        checks++;
        if (d_occ !== 3'd0) begin errors++; $display("FAIL byp_occ got %0d expected 0", d_occ); end
`endif
        tick();
        $display("test_bypass done");
    endtask

    initial begin
        a_sdata = '0; a_skeep = '0; a_svalid = 1'b0; a_slast = 1'b0; a_suser = '0; a_mready = 1'b0;
        b_sdata = '0; b_skeep = '0; b_svalid = 1'b0; b_slast = 1'b0; b_suser = '0; b_mready = 1'b0;
        c_sdata = '0; c_skeep = '0; c_svalid = 1'b0; c_slast = 1'b0; c_suser = '0; c_mready = 1'b0;
        d_sdata = '0; d_skeep = '0; d_svalid = 1'b0; d_slast = 1'b0; d_suser = '0; d_mready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_simple();
        test_random();
        test_reset_mid();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
